// File: rtl/slot_pwr_pkg.sv
// Shared state encodings, counter width and output decode for the slot power sequencer.
package slot_pwr_pkg;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_PWR_ON     = 3'd1,
    ST_PERST_WAIT = 3'd2,
    ST_RUN        = 3'd3,
    ST_PWR_OFF    = 3'd4,
    ST_FAULT      = 3'd5
  } state_e;

  typedef struct packed {
    logic pwr_en;
    logic perst_n;
    logic fault;
  } slot_out_t;

  // Output decode for a given state; unused encodings decode to all-off.
  function automatic slot_out_t state_outs(input state_e s);
    slot_out_t o;
    o = '0;
    case (s)
      ST_PWR_ON:     o.pwr_en = 1'b1;
      ST_PERST_WAIT: o.pwr_en = 1'b1;
      ST_RUN: begin
        o.pwr_en  = 1'b1;
        o.perst_n = 1'b1;
      end
      ST_FAULT:      o.fault = 1'b1;
      default:       o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/slot_pwr_seq.sv
// Slot power sequencer: power enable, power-good wait, PERST release, removal and fault handling.
// Optional auto-retry out of FAULT is enabled by defining SLOT_PWR_RETRY_EN.
module slot_pwr_seq
  import slot_pwr_pkg::*;
#(
  parameter int unsigned PG_TIMEOUT_MS = 100,
  parameter int unsigned PERST_DLY_MS  = 100,
  parameter int unsigned OFF_DLY_MS    = 20,
  parameter int unsigned RETRY_MS      = 1000
) (
  input  logic            clk_1k,
  input  logic            cpld_rst,
  input  logic            prsnt_db,
  input  logic            pwr_good,
  output logic            pwr_en,
  output logic            perst_n,
  output logic            fault,
  output logic [ST_W-1:0] state
);

  localparam logic [CNT_W-1:0] PG_LAST    = CNT_W'(PG_TIMEOUT_MS - 1);
  localparam logic [CNT_W-1:0] PERST_LAST = CNT_W'(PERST_DLY_MS - 1);
  localparam logic [CNT_W-1:0] OFF_LAST   = CNT_W'(OFF_DLY_MS - 1);
  localparam logic [CNT_W-1:0] RETRY_LAST = CNT_W'(RETRY_MS - 1);

`ifdef SLOT_PWR_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  state_e           cur;
  state_e           nxt;
  logic [CNT_W-1:0] cnt;
  logic             pg_s;
  slot_out_t        outs_d;

  sync_2ff u_pg_sync (
    .clk (clk_1k),
    .rst (cpld_rst),
    .d   (pwr_good),
    .q   (pg_s)
  );

  // State register; outputs are registered from the next-state decode so they
  // change on the same edge as the transition.
  always_ff @(posedge clk_1k) begin
    if (cpld_rst) begin
      cur     <= ST_IDLE;
      pwr_en  <= 1'b0;
      perst_n <= 1'b0;
      fault   <= 1'b0;
    end else begin
      cur     <= nxt;
      pwr_en  <= outs_d.pwr_en;
      perst_n <= outs_d.perst_n;
      fault   <= outs_d.fault;
    end
  end

  // Millisecond counter: restarts on every transition, saturates at all-ones.
  always_ff @(posedge clk_1k) begin
    if (cpld_rst) begin
      cnt <= '0;
    end else if (nxt != cur) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Next-state logic; card removal outranks every power-good event.
  always_comb begin
    nxt = cur;
    case (cur)
      ST_IDLE: begin
        if (!prsnt_db) nxt = ST_PWR_ON;
      end
      ST_PWR_ON: begin
        if (prsnt_db)            nxt = ST_PWR_OFF;
        else if (pg_s)           nxt = ST_PERST_WAIT;
        else if (cnt == PG_LAST) nxt = ST_FAULT;
      end
      ST_PERST_WAIT: begin
        if (prsnt_db)               nxt = ST_PWR_OFF;
        else if (!pg_s)             nxt = ST_FAULT;
        else if (cnt == PERST_LAST) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (prsnt_db)   nxt = ST_PWR_OFF;
        else if (!pg_s) nxt = ST_FAULT;
      end
      ST_PWR_OFF: begin
        if (cnt == OFF_LAST) nxt = ST_IDLE;
      end
      ST_FAULT: begin
        if (prsnt_db)                           nxt = ST_IDLE;
        else if (RETRY_EN && cnt == RETRY_LAST) nxt = ST_PWR_OFF;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  // Output decode of the state being entered.
  always_comb begin
    outs_d = '0;
    outs_d = state_outs(nxt);
  end

  assign state = cur;

endmodule

// File: tb/tb_slot_pwr_seq.sv
// Scoreboard bench for slot_pwr_seq: stimulus queues expected output changes, a monitor checks them.
module tb_slot_pwr_seq;

  logic       clk_1k = 1'b0;
  logic       cpld_rst;
  logic       prsnt_db;
  logic       pwr_good;
  logic       pwr_en;
  logic       perst_n;
  logic       fault;
  logic [2:0] state;

  always #5 clk_1k = ~clk_1k;

  slot_pwr_seq #(
    .PG_TIMEOUT_MS (100),
    .PERST_DLY_MS  (100),
    .OFF_DLY_MS    (20),
    .RETRY_MS      (50)
  ) dut (
    .clk_1k   (clk_1k),
    .cpld_rst (cpld_rst),
    .prsnt_db (prsnt_db),
    .pwr_good (pwr_good),
    .pwr_en   (pwr_en),
    .perst_n  (perst_n),
    .fault    (fault),
    .state    (state)
  );

  typedef struct {
    int         edge_no;
    logic [5:0] outs;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  logic [5:0] prev = '0;

  always @(posedge clk_1k) cyc <= cyc + 1;

  // Expected {state, pwr_en, perst_n, fault} after posedge number e.
  task automatic expect_at(input int e, input logic [2:0] st, input logic en,
                           input logic pn, input logic flt);
    exp_t x;
    x.edge_no = e;
    x.outs    = {st, en, pn, flt};
    sb.push_back(x);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_1k);
  endtask

  // Monitor: every change of the output tuple must match the next queued expectation.
  always @(negedge clk_1k) begin : mon
    logic [5:0] cur;
    exp_t       x;
    if (mon_en) begin
      cur = {state, pwr_en, perst_n, fault};
      tests++;
      if (perst_n && !pwr_en) begin
        fails++;
        $display("FAIL perst_gate cycle=%0d perst_n=%b pwr_en=%b", cyc, perst_n, pwr_en);
      end
      tests++;
      if (fault != (state == 3'd5)) begin
        fails++;
        $display("FAIL fault_flag cycle=%0d fault=%b state=%0d", cyc, fault, state);
      end
      if (cur != prev) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_change cycle=%0d got=%b prev=%b", cyc, cur, prev);
        end else begin
          x = sb.pop_front();
          if (cur != x.outs) begin
            fails++;
            $display("FAIL outputs cycle=%0d got=%b want=%b", cyc, cur, x.outs);
          end
          tests++;
          if (cyc != x.edge_no) begin
            fails++;
            $display("FAIL timing got_edge=%0d want_edge=%0d outs=%b", cyc, x.edge_no, cur);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    int k;
    cpld_rst = 1'b1;
    prsnt_db = 1'b1;
    pwr_good = 1'b0;
    step(3);
    tests++;
    if ({state, pwr_en, perst_n, fault} != 6'b0) begin
      fails++;
      $display("FAIL reset_state got=%b want=%b", {state, pwr_en, perst_n, fault}, 6'b0);
    end
    prev   = {state, pwr_en, perst_n, fault};
    mon_en = 1'b1;
    cpld_rst = 1'b0;
    step(3);

    // Normal insert, power-good arrives 10 ms later
    k = cyc;
    prsnt_db = 1'b0;
    expect_at(k + 1, 3'd1, 1'b1, 1'b0, 1'b0);
    step(10);
    pwr_good = 1'b1;
    expect_at(k + 13,  3'd2, 1'b1, 1'b0, 1'b0);
    expect_at(k + 113, 3'd3, 1'b1, 1'b1, 1'b0);
    step(110);

    // Removal in RUN
    k = cyc;
    prsnt_db = 1'b1;
    expect_at(k + 1,  3'd4, 1'b0, 1'b0, 1'b0);
    expect_at(k + 21, 3'd0, 1'b0, 1'b0, 1'b0);
    step(25);

    // Re-insert with power already good, then removal and pg loss on the same edge
    k = cyc;
    prsnt_db = 1'b0;
    expect_at(k + 1,   3'd1, 1'b1, 1'b0, 1'b0);
    expect_at(k + 2,   3'd2, 1'b1, 1'b0, 1'b0);
    expect_at(k + 102, 3'd3, 1'b1, 1'b1, 1'b0);
    step(110);
    k = cyc;
    pwr_good = 1'b0;
    step(2);
    prsnt_db = 1'b1;
    expect_at(k + 3,  3'd4, 1'b0, 1'b0, 1'b0);
    expect_at(k + 23, 3'd0, 1'b0, 1'b0, 1'b0);
    step(25);

    // Power-good timeout
    k = cyc;
    prsnt_db = 1'b0;
    expect_at(k + 1,   3'd1, 1'b1, 1'b0, 1'b0);
    expect_at(k + 101, 3'd5, 1'b0, 1'b0, 1'b1);
`ifdef SLOT_PWR_RETRY_EN
    expect_at(k + 151, 3'd4, 1'b0, 1'b0, 1'b0);
    expect_at(k + 171, 3'd0, 1'b0, 1'b0, 1'b0);
    expect_at(k + 172, 3'd1, 1'b1, 1'b0, 1'b0);
    step(180);
    k = cyc;
    prsnt_db = 1'b1;
    expect_at(k + 1,  3'd4, 1'b0, 1'b0, 1'b0);
    expect_at(k + 21, 3'd0, 1'b0, 1'b0, 1'b0);
    step(25);
`else
    step(300);
    tests++;
    if (state != 3'd5 || fault != 1'b1) begin
      fails++;
      $display("FAIL fault_hold state=%0d fault=%b want state=5 fault=1", state, fault);
    end
    k = cyc;
    prsnt_db = 1'b1;
    expect_at(k + 1, 3'd0, 1'b0, 1'b0, 1'b0);
    step(5);
`endif

    // Reset pulse at PERST_WAIT cycle 40, then full re-sequence from IDLE
    pwr_good = 1'b1;
    step(4);
    k = cyc;
    prsnt_db = 1'b0;
    expect_at(k + 1, 3'd1, 1'b1, 1'b0, 1'b0);
    expect_at(k + 2, 3'd2, 1'b1, 1'b0, 1'b0);
    step(42);
    cpld_rst = 1'b1;
    expect_at(k + 43, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1);
    cpld_rst = 1'b0;
    expect_at(k + 44,  3'd1, 1'b1, 1'b0, 1'b0);
    expect_at(k + 46,  3'd2, 1'b1, 1'b0, 1'b0);
    expect_at(k + 146, 3'd3, 1'b1, 1'b1, 1'b0);
    step(110);
    k = cyc;
    prsnt_db = 1'b1;
    expect_at(k + 1,  3'd4, 1'b0, 1'b0, 1'b0);
    expect_at(k + 21, 3'd0, 1'b0, 1'b0, 1'b0);
    step(25);

    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL pending_expectations left=%0d want=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slot_pwr_seq.md
SLOT_PWR_SEQ -- requirements
Module: slot_pwr_seq

Interface
REQ-001 SHALL have parameter PG_TIMEOUT_MS, default 100, max clk_1k cycles to wait for power-good after enable.
REQ-002 SHALL have parameter PERST_DLY_MS, default 100, cycles from power-good to PERST de-assert.
REQ-003 SHALL have parameter OFF_DLY_MS, default 20, discharge hold time after power-off.
REQ-004 SHALL have parameter RETRY_MS, default 1000, fault cool-down before auto-retry (used only with SLOT_PWR_RETRY_EN).
REQ-005 clk_1k  input  1  1 kHz clock; single clock domain for the block.
REQ-006 cpld_rst  input  1  reset, synchronous, active-high.
REQ-007 prsnt_db  input  1  debounced slot presence from upstream debounce stage, 1 = card absent, 0 = card present.
REQ-008 pwr_good  input  1  slot power-good from hot-swap controller, asynchronous, 1 = good.
REQ-009 pwr_en  output  1  slot power enable, 1 = on.
REQ-010 perst_n  output  1  slot reset to card, active-low.
REQ-011 fault  output  1  1 = slot in FAULT state.
REQ-012 state  output  3  current FSM state encoding, for status registers.

Function
REQ-013 pwr_good SHALL pass a 2-flop synchronizer; pg_s denotes the synchronized value (2-cycle latency).
REQ-014 FSM states SHALL be IDLE=0, PWR_ON=1, PERST_WAIT=2, RUN=3, PWR_OFF=4, FAULT=5; encodings 6/7 SHALL return to IDLE next cycle.
REQ-015 All outputs SHALL be registered and change on the same clk_1k edge as the state transition that defines them.
REQ-016 One 16-bit millisecond counter SHALL clear on every state transition, increment each cycle otherwise, and saturate at 0xFFFF.
REQ-017 IDLE: pwr_en=0, perst_n=0; prsnt_db=0 -> PWR_ON.
REQ-018 PWR_ON: pwr_en=1, perst_n=0; pg_s=1 -> PERST_WAIT; counter==PG_TIMEOUT_MS-1 with pg_s=0 -> FAULT.
REQ-019 PERST_WAIT: pwr_en=1, perst_n=0; counter==PERST_DLY_MS-1 -> RUN; pg_s=0 -> FAULT.
REQ-020 RUN: pwr_en=1, perst_n=1; pg_s=0 -> FAULT.
REQ-021 PWR_OFF: pwr_en=0, perst_n=0; counter==OFF_DLY_MS-1 -> IDLE.
REQ-022 FAULT: pwr_en=0, perst_n=0, fault=1; prsnt_db=1 -> IDLE.
REQ-023 In PWR_ON, PERST_WAIT and RUN, prsnt_db=1 -> PWR_OFF, and removal SHALL take priority over every pg_s event in the same cycle.
REQ-024 perst_n SHALL never be 1 while pwr_en is 0 in any cycle.
REQ-025 fault SHALL be 0 in every state except FAULT.

Reset
REQ-026 While cpld_rst=1 on a clk_1k edge: state=IDLE, counter=0, synchronizer flops=0, pwr_en=0, perst_n=0, fault=0.
REQ-027 Reset asserted mid-sequence (any state) SHALL drop pwr_en and perst_n on that edge.
REQ-028 After reset release, the block SHALL start from IDLE; it SHALL NOT resume the prior state.

Configuration
REQ-029 Macro SLOT_PWR_RETRY_EN defined: in FAULT with prsnt_db=0, counter==RETRY_MS-1 -> PWR_OFF, which leads to IDLE and re-power.
REQ-030 SLOT_PWR_RETRY_EN undefined: FAULT exits only on prsnt_db=1, and RETRY_MS is unused.

Structure
REQ-031 State encodings and the counter width constant SHALL live in shared package slot_pwr_pkg.
REQ-032 The 2-flop synchronizer SHALL be sub-module sync_2ff; everything else is flat in slot_pwr_seq.

Verification
REQ-033 Normal insert with defaults: prsnt_db 1->0, pwr_good=1 at 10 ms. Expected: pwr_en=1 one cycle after insert; perst_n=1 exactly 100 cycles after pg_s rises; state=3.
REQ-034 PG timeout: insert, pwr_good held 0. Expected: at cycle 100 of PWR_ON, pwr_en=0, fault=1, state=5; with retry off, stays in FAULT until prsnt_db=1.
REQ-035 Removal in RUN: prsnt_db 0->1. Expected: next edge pwr_en=0, perst_n=0, state=4; IDLE after 20 cycles.
REQ-036 Simultaneous events: prsnt_db=1 and pg_s=0 in the same cycle in RUN. Expected: PWR_OFF, not FAULT; fault stays 0.
REQ-037 Retry build (SLOT_PWR_RETRY_EN, RETRY_MS=50): PG timeout, card kept present. Expected: FAULT for 50 cycles, PWR_OFF for 20 cycles, IDLE, then pwr_en=1 again.
REQ-038 Mid-sequence reset: cpld_rst=1 for 1 cycle at PERST_WAIT cycle 40. Expected: all outputs 0 that edge, state=0, then re-sequence from IDLE.
